// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: decodes the latched instruction fields, drives the
// datapath enables and mux selects, and counts retired instructions.
module mc_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        i_or_d,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        err,
    output logic [31:0] ret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        is_store_r;
    logic [31:0] ret_cnt_r;
    logic        done_s;
    logic [3:0]  funct_dec_s;

    // R-type funct decode: {legal, alu_ctrl}
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        logic [3:0] r;
        case (f)
            6'b100000: r = {1'b1, 3'b010};
            6'b100010: r = {1'b1, 3'b110};
            6'b100100: r = {1'b1, 3'b000};
            6'b100101: r = {1'b1, 3'b001};
            6'b101010: r = {1'b1, 3'b111};
            default:   r = {1'b0, 3'b000};
        endcase
        return r;
    endfunction

    assign funct_dec_s = decode_funct(funct);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEMADR needs lw/sw after op has moved on, so remember it from DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_r <= 1'b0;
        end else if (state_r == S_DECODE) begin
            is_store_r <= (op == OP_SW);
        end else begin
            is_store_r <= is_store_r;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_cnt_r <= 32'd0;
        end else if (done_s) begin
            ret_cnt_r <= ret_cnt_r + 32'd1;
        end else begin
            ret_cnt_r <= ret_cnt_r;
        end
    end

    // Next-state and Moore output decode (pc_wr in BEQ follows zero)
    always_comb begin
        state_nxt_s = state_r;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        i_or_d      = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = 3'b000;
        pc_src      = 2'b00;
        err         = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                pc_wr       = 1'b1;
                ir_wr       = 1'b1;
                alu_src_b   = 2'b01;
                alu_ctrl    = 3'b010;
                state_nxt_s = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = 3'b010;
                case (op)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_BEQ:       state_nxt_s = S_BEQ;
                    OP_ADDI:      state_nxt_s = S_ADDIEX;
                    OP_J:         state_nxt_s = S_JUMP;
                    default:      state_nxt_s = S_ERR;
                endcase
                if (op == OP_RTYPE) begin
                    state_nxt_s = funct_dec_s[3] ? S_EXEC : S_ERR;
                end else begin
                    state_nxt_s = state_nxt_s;
                end
                // Non-halting build retires an illegal instruction as a NOP
                if ((state_nxt_s == S_ERR) && !HALT_ON_ILLEGAL) begin
                    state_nxt_s = S_FETCH;
                    done_s      = 1'b1;
                end else begin
                    done_s      = 1'b0;
                end
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_ctrl    = 3'b010;
                if (state_r == S_ADDIEX) begin
                    state_nxt_s = S_ADDIWB;
                end else begin
                    state_nxt_s = is_store_r ? S_MEMWR : S_MEMRD;
                end
            end
            S_MEMRD: begin
                i_or_d      = 1'b1;
                state_nxt_s = S_MEMWB;
            end
            S_MEMWB: begin
                reg_wr      = 1'b1;
                mem_to_reg  = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_wr      = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_ctrl    = funct_dec_s[2:0];
                state_nxt_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr      = 1'b1;
                reg_dst     = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_ADDIWB: begin
                reg_wr      = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 1'b1;
                alu_ctrl    = 3'b110;
                pc_src      = 2'b01;
                pc_wr       = zero;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_JUMP: begin
                pc_wr       = 1'b1;
                pc_src      = 2'b10;
                done_s      = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_ERR: begin
                err         = 1'b1;
                state_nxt_s = S_ERR;
            end
            default: state_nxt_s = S_FETCH;
        endcase
    end

    assign state      = state_r;
    assign instr_done = done_s;
    assign ret_cnt    = ret_cnt_r;

endmodule
